// File: rtl/traffic_pkg.sv
// traffic_pkg: shared FSM state encoding, lamp patterns and display constants
package traffic_pkg;

    typedef enum logic [2:0] {
        ALLRED = 3'd0,
        NS     = 3'd1,
        EW     = 3'd2,
        PED    = 3'd3,
        FLASH  = 3'd4
    } state_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] OFF    = 3'b000;
    localparam logic [3:0] BLANK  = 4'hF;

endpackage

// File: rtl/traffic_light_ctrl_sync_edge.sv
// sync_edge: 2-FF synchronizer with registered rising-edge strobe
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous level input
//   level      : synchronized level (2 clk latency)
//   rise       : one-clk strobe on a rising edge of d, valid together with level
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);
    logic s1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1    <= d;
            level <= s1;
            rise  <= s1 & ~level;
        end
    end
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road intersection sequencer driven by the 1 s backcounter
//   Build option: define TRAFFIC_PED_EN to include the pedestrian phase.
//   clk, rst_n        : clock, async active-low reset
//   pulse_1s, count   : shared second strobe and upstream remaining seconds
//   ped_req           : async pedestrian button (ignored without TRAFFIC_PED_EN)
//   night_mode        : async night request level
//   ns_light,ew_light : {R,Y,G} per road
//   walk, ped_pending : pedestrian lamp and latched-request flag
//   phase             : current state encoding
//   disp_tens/ones    : BCD remaining seconds, blank (F) in FLASH
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int T        = 10,
    parameter int YELLOW_S = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pulse_1s,
    input  logic [3:0] count,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_ones
);
    // Yellow threshold held inside its legal range 0..T-1
    localparam logic [3:0] YS = 4'((YELLOW_S < T) ? YELLOW_S : T - 1);

    state_t     state_q, state_n;
    logic       last_ew, flash_q, night, unused_night_rise, go_ped;
    logic       exp_s;
    logic [2:0] ns_n, ew_n, road;
    logic [3:0] tens_n, ones_n;

    assign exp_s = pulse_1s && count == 4'd0;

    sync_edge u_night (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (night_mode),
        .level(night),
        .rise (unused_night_rise)
    );

`ifdef TRAFFIC_PED_EN
    logic ped_rise, unused_ped_level, pend_q;
    sync_edge u_ped (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ped_req),
        .level(unused_ped_level),
        .rise (ped_rise)
    );
    assign go_ped      = pend_q;
    assign ped_pending = pend_q;
    // Clearing on PED/FLASH entry wins over a coincident new edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            walk   <= 1'b0;
        end else begin
            walk <= state_q == PED;
            if (state_q != state_n && (state_n == PED || state_n == FLASH))
                pend_q <= 1'b0;
            else if (ped_rise && state_q != PED && state_q != FLASH)
                pend_q <= 1'b1;
        end
    end
`else
    logic unused_ped;
    assign unused_ped  = ped_req;
    assign go_ped      = 1'b0;
    assign ped_pending = 1'b0;
    assign walk        = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        if (exp_s) begin
            case (state_q)
                ALLRED:  state_n = NS;
                NS:      state_n = go_ped ? PED : EW;
                EW:      state_n = go_ped ? PED : NS;
                PED:     state_n = last_ew ? NS : EW;
                default: state_n = ALLRED;
            endcase
            if (night)
                state_n = FLASH;
        end
    end

    always_comb begin
        road   = (count > YS) ? GREEN : YELLOW;
        ns_n   = RED;
        ew_n   = RED;
        tens_n = count / 4'd10;
        ones_n = count % 4'd10;
        case (state_q)
            NS: ns_n = road;
            EW: ew_n = road;
            FLASH: begin
                ns_n   = flash_q ? YELLOW : OFF;
                ew_n   = flash_q ? YELLOW : OFF;
                tens_n = BLANK;
                ones_n = BLANK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ALLRED;
            last_ew   <= 1'b1;
            flash_q   <= 1'b0;
            ns_light  <= RED;
            ew_light  <= RED;
            phase     <= ALLRED;
            disp_tens <= 4'd0;
            disp_ones <= 4'd0;
        end else begin
            state_q   <= state_n;
            ns_light  <= ns_n;
            ew_light  <= ew_n;
            phase     <= state_q;
            disp_tens <= tens_n;
            disp_ones <= ones_n;
            if (state_n == NS)
                last_ew <= 1'b0;
            else if (state_n == EW)
                last_ew <= 1'b1;
            if (state_q != FLASH && state_n == FLASH)
                flash_q <= 1'b0;
            else if (state_q == FLASH && pulse_1s)
                flash_q <= ~flash_q;
        end
    end
endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Two-road intersection controller sitting directly downstream of the per-second backcounter. It consumes the counter's `count` value and the shared `pulse_1s` strobe. It sequences vehicle lights (NS/EW), an optional pedestrian phase and a night flashing mode. It also drives a two-digit BCD display of the remaining seconds. One phase lasts one full counter period (T+1 seconds, expiry to expiry).

## Interface
Parameters:
- `T`, default 10: counter reload value; must equal the upstream counter's T.
- `YELLOW_S`, default 3: the active road shows yellow while `count <= YELLOW_S`. Legal range is 0..T-1.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pulse_1s`, in, 1: one-clk strobe per second, shared with the counter.
- `count`, in, 4: upstream remaining seconds.
- `ped_req`, in, 1: asynchronous pedestrian button, level.
- `night_mode`, in, 1: asynchronous night request, level.
- `ns_light`, out, 3: {R,Y,G} for the NS road.
- `ew_light`, out, 3: {R,Y,G} for the EW road.
- `walk`, out, 1: pedestrian walk lamp.
- `ped_pending`, out, 1: a request is latched and not yet served.
- `phase`, out, 3: current FSM state encoding.
- `disp_tens`, out, 4: BCD tens digit of the display.
- `disp_ones`, out, 4: BCD ones digit of the display.

## Operation
- **Expiry event:** `exp = pulse_1s && count == 0`. FSM state changes only on `exp`.
- **States:** ALLRED (reset), NS, EW, PED, FLASH. A `last_road` bit records the last road served; reset value is EW.
- **Transitions on `exp`:**
  - ALLRED → NS.
  - NS → PED if `ped_pending`, else EW.
  - EW → PED if `ped_pending`, else NS.
  - PED → the road other than `last_road`.
  - FLASH → ALLRED if night is low, else stays in FLASH.
  - Any state → FLASH when synchronized night is high. This has priority over PED.
- **Lights:**
  - NS/EW: the active road is GREEN while `count > YELLOW_S` and YELLOW while `count <= YELLOW_S`. The other road is RED.
  - ALLRED and PED: both roads RED.
  - PED: `walk`=1. In every other state `walk`=0.
  - FLASH: both roads show YELLOW when `flash`=1 and OFF (000) when `flash`=0. `flash` toggles on each `pulse_1s` and clears on FLASH entry.
- **Pedestrian request:**
  - `ped_req` passes through a 2-FF synchronizer and a rising-edge detector.
  - An edge sets `ped_pending`. The flag clears on the clk edge that enters PED.
  - Edges arriving while in PED or FLASH are discarded.
  - Entering FLASH clears `ped_pending`.
- **Night mode:** `night_mode` passes through a 2-FF synchronizer and is used as a level.
- **Display:**
  - `disp_tens` = `count` / 10 and `disp_ones` = `count` % 10, valid for 0..15.
  - In FLASH both digits are 4'hF (blank).
- **Reset values (all outputs):**
  - `ns_light` = `ew_light` = 3'b100.
  - `walk` = 0, `ped_pending` = 0.
  - `phase` = ALLRED.
  - `disp_tens` = `disp_ones` = 0.
  - `flash` = 0.
- **Reset mid-operation:** all outputs return immediately (asynchronously) to their reset values. Any pending request is lost.

## Timing
- State register updates on the clk edge that samples `exp`.
- All outputs are registered from the current state, `count` and `flash`. They lag state and `count` by exactly 1 clk.
- `ped_req` rising edge → `ped_pending` high 3 clk later (2 sync stages plus the edge register).
- `night_mode` change → visible to the FSM 2 clk later. A FLASH transition occurs at the first `exp` after that.
- Simultaneous `exp` and request edge: the transition uses the pre-edge `ped_pending`. A request from NS/EW is still latched and served at the following `exp`.

## Configuration
- Macro `TRAFFIC_PED_EN`, defined:
  - PED state, `ped_req` synchronizer and `ped_pending` logic are present.
- Macro `TRAFFIC_PED_EN`, undefined:
  - Ports are kept. `ped_req` is ignored.
  - `walk` and `ped_pending` are constant 0.
  - NS and EW alternate directly.

## Structure
- Package `traffic_pkg` holds:
  - The state enum (ALLRED=0, NS=1, EW=2, PED=3, FLASH=4).
  - Light constants: RED=3'b100, YELLOW=3'b010, GREEN=3'b001, OFF=3'b000.
  - Blank digit 4'hF.
- Sub-module `sync_edge`: 2-FF synchronizer with registered rising-edge output. One instance each for `ped_req` and `night_mode` (the night instance uses the level output).

## Test plan
- **Normal cycle:** reset, T=10, YELLOW_S=3, `pulse_1s` every 4 clk → ALLRED until the first `exp`. NS is GREEN for `count` 10..4 and YELLOW for 3..0; EW is RED throughout. Then EW follows with the same pattern.
- **Pedestrian request:** 3-clk `ped_req` pulse during NS → `ped_pending`=1 3 clk later. At the next `exp`: PED, `walk`=1, both roads RED, `ped_pending`=0. The following `exp` goes to EW.
- **Night mode:** `night_mode`=1 during EW → EW holds until `exp`, then FLASH. Lights alternate YELLOW/OFF on each pulse and display shows F/F. After `night_mode`=0, the next `exp` goes to ALLRED, and the `exp` after that goes to NS.
- **Display:** `count`=12 → `disp_tens`=1, `disp_ones`=2 one clk later. `count`=7 → 0/7.
- **Reset mid-phase:** assert `rst_n`=0 mid-PED → immediately `ns_light`=`ew_light`=3'b100, `walk`=0, `ped_pending`=0. After release, state is ALLRED.
- **Build without `TRAFFIC_PED_EN`:** `ped_req` pulses → `walk`/`ped_pending` stay 0 and the sequence is NS→EW→NS.
